// File: rtl/fadd_pkg.sv
// fadd_pkg: shared constants and types for the fadd pipeline and its
// stream controller.
//   FADD_LAT    : cycles from fadd.en to fadd.res_val
//   N_DEF/E_DEF/S_DEF : default float width / exponent / significand bits
//   TAG_W_DEF   : default user tag width
//   fadd_res_t  : {res, tag} result entry at default widths
package fadd_pkg;

  localparam int FADD_LAT  = 3;
  localparam int N_DEF     = 32;
  localparam int E_DEF     = 8;
  localparam int S_DEF     = 23;
  localparam int TAG_W_DEF = 4;

  typedef struct packed {
    logic [N_DEF-1:0]     res;
    logic [TAG_W_DEF-1:0] tag;
  } fadd_res_t;

  // Width of an occupancy counter able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fadd_sfifo.sv
// fadd_sfifo: synchronous FIFO with a registered head.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   head       : oldest entry, held in a register so it is stable while
//                the consumer stalls
//   count      : occupancy 0..DEPTH
//   full/empty : occupancy flags
module fadd_sfifo
  import fadd_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [W-1:0]  head_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full       = (count_reg == CW'(DEPTH));
  assign empty      = (count_reg == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;   // DEPTH is a power of 2: wraps naturally

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok)
      count_next = count_reg + 1'b1;
    else if (!push_ok && pop_ok)
      count_next = count_reg - 1'b1;
  end

  // Storage array carries no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      count_reg <= count_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_inc;
      // Head update: a write into an empty (or just-emptied) FIFO lands
      // straight in the head register; otherwise a pop loads the next
      // stored entry, which is already in RAM when count > 1.
      if (push_ok && ((count_reg == '0) || ((count_reg == CW'(1)) && pop_ok)))
        head_reg <= din;
      else if (pop_ok && (count_reg > CW'(1)))
        head_reg <= mem[rd_ptr_inc];
    end
  end

  assign head  = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/fadd_stream_ctrl.sv
// fadd_stream_ctrl: valid/ready wrapper around the 3-cycle fadd pipeline.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid/in_ready              : operand pair handshake
//   in_op1, in_op2, in_tag         : operands and user tag
//   fadd_en, fadd_op1, fadd_op2    : issue port to fadd (combinational)
//   fadd_res_val, fadd_res         : result port from fadd
//   out_valid/out_ready            : result handshake
//   out_res, out_tag               : result and its tag (registered head)
//   busy                           : ops in flight or results buffered
//   err_orphan                     : sticky, result with nothing in flight
//   err_ovf                        : sticky, result while result FIFO full
module fadd_stream_ctrl
  import fadd_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_op1,
  input  logic [N-1:0]     in_op2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             fadd_en,
  output logic [N-1:0]     fadd_op1,
  output logic [N-1:0]     fadd_op2,
  input  logic             fadd_res_val,
  input  logic [N-1:0]     fadd_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy,
  output logic             err_orphan,
  output logic             err_ovf
);

  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [N-1:0]     res;
    logic [TAG_W-1:0] tag;
  } res_entry_t;

  logic             fire;
  logic [TAG_W-1:0] tag_head;
  logic [CW-1:0]    inflight;
  logic             tag_full;
  logic             tag_empty;

  res_entry_t       res_din;
  res_entry_t       res_head;
  logic [CW-1:0]    res_count;
  logic             res_full;
  logic             res_empty;
  logic             res_push;
  logic             res_pop;

  logic             orphan;
  logic             ovf;
  logic             err_orphan_reg;
  logic             err_ovf_reg;

  // Credit from registered counts only: a pop this cycle frees a slot
  // starting next cycle, which keeps in_ready off the out_ready path.
  // The tag_full term is implied by the sum check and only guards the FIFO.
  assign in_ready = ((CW + 1)'(inflight) + (CW + 1)'(res_count) < (CW + 1)'(DEPTH))
                    & ~tag_full;
  assign fire     = in_valid & in_ready;
  assign fadd_en  = fire;
  assign fadd_op1 = in_op1;
  assign fadd_op2 = in_op2;

  // Tag FIFO: one entry per op in flight inside fadd.
  fadd_sfifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fire),
    .din   (in_tag),
    .pop   (fadd_res_val),
    .head  (tag_head),
    .count (inflight),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // A result with no matching tag is dropped; a result that finds the
  // result FIFO full is dropped but still retires its tag.
  assign orphan   = fadd_res_val & tag_empty;
  assign ovf      = fadd_res_val & ~tag_empty & res_full;
  assign res_push = fadd_res_val & ~tag_empty & ~res_full;
  assign res_din  = '{res: fadd_res, tag: tag_head};
  assign res_pop  = out_valid & out_ready;

  fadd_sfifo #(
    .W     ($bits(res_entry_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .din   (res_din),
    .pop   (res_pop),
    .head  (res_head),
    .count (res_count),
    .full  (res_full),
    .empty (res_empty)
  );

  assign out_valid = ~res_empty;
  assign out_res   = res_head.res;
  assign out_tag   = res_head.tag;
  assign busy      = (inflight != '0) | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_orphan_reg <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      if (orphan)
        err_orphan_reg <= 1'b1;
      if (ovf)
        err_ovf_reg <= 1'b1;
    end
  end

  assign err_orphan = err_orphan_reg;
  assign err_ovf    = err_ovf_reg;

endmodule

// File: doc/fadd_stream_ctrl.md
# fadd_stream_ctrl

Valid/ready wrapper around the 3-cycle `fadd` pipeline. It accepts operand pairs with a tag, issues them to `fadd` without back-pressure hazards, and captures each result with its tag. Results go into an output FIFO drained through a valid/ready port. Issue is credit-limited, so a result returned by `fadd` is never dropped. The block sits between the operand scheduler (upstream) and the `fadd` instance plus the result consumer (downstream).

## Interface
Parameters:
- `N`, 32: float width; passed through to `fadd`.
- `TAG_W`, 4: width of the user tag carried alongside each operation.
- `DEPTH`, 8: entries in each FIFO, power of 2, ≥ 2. Must be ≥ `FADD_LAT`+2 for 1 op/cycle throughput.

Ports:
- `clk`, in, 1: single clock. All state is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `in_valid`, in, 1: operand pair offered.
- `in_ready`, out, 1: pair accepted this cycle when `in_valid` & `in_ready`.
- `in_op1`, `in_op2`, in, N: operands.
- `in_tag`, in, TAG_W: tag returned with the result.
- `fadd_en`, out, 1: issue strobe to `fadd.en`.
- `fadd_op1`, `fadd_op2`, out, N: connect to `fadd.op1` and `fadd.op2`.
- `fadd_res_val`, in, 1: from `fadd.res_val`.
- `fadd_res`, in, N: from `fadd.res`.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: consumer takes the result.
- `out_res`, out, N: result value.
- `out_tag`, out, TAG_W: tag of the result.
- `busy`, out, 1: any op in flight or any result buffered.
- `err_orphan`, out, 1: sticky. Set when `fadd_res_val` arrives with no op in flight.
- `err_ovf`, out, 1: sticky. Set when `fadd_res_val` arrives with the result FIFO full.

## Operation
- Tag FIFO tracks in-flight ops:
  - Push `in_tag` on fire (`in_valid & in_ready`).
  - Pop on `fadd_res_val`.
  - `inflight` = its occupancy.
- Result FIFO holds `{res, tag}`:
  - Push `{fadd_res, tag FIFO head}` on `fadd_res_val`.
  - Pop on `out_valid & out_ready`.
- Credit rule: `in_ready = (inflight + res_count) < DEPTH`. It is computed from registered counts only. A same-cycle pop does not grant credit.
- Issue path:
  - `fadd_en = in_valid & in_ready`.
  - `fadd_op1`/`fadd_op2` are combinational pass-through of `in_op1`/`in_op2`.
  - Nothing is registered on the issue path.
- Orphan result (tag FIFO empty): result is dropped, no push, `err_orphan` set.
- Result FIFO full on `fadd_res_val`: result is dropped, tag FIFO still pops, `err_ovf` set. This is unreachable under the credit rule.
- Simultaneous events:
  - Issue and result in the same cycle: tag FIFO pushes and pops; `inflight` is unchanged.
  - Result-push and out-pop in the same cycle: `res_count` is unchanged.
- `busy = (inflight != 0) | out_valid`.

## Timing
- Reset values: `in_ready`=1 (combinational from zeroed counts), `fadd_en`=0, `out_valid`=0, `out_res`=0, `out_tag`=0, `busy`=0, `err_orphan`=0, `err_ovf`=0. All counts and pointers are 0.
- `fadd` latency `FADD_LAT`=3: fire in cycle t gives `fadd_res_val` in cycle t+3.
- Result FIFO has no bypass:
  - `out_valid` rises in cycle t+4 when the FIFO was empty.
  - End-to-end latency is 4 cycles.
- Output data is driven from FIFO head registers, so it is stable while `out_valid & !out_ready`.
- Throughput with `DEPTH`=8 and `out_ready` held at 1: one op per cycle, sustained.
- Back-pressure: with `out_ready`=0, exactly `DEPTH` ops are accepted. `in_ready` then stays 0 until a pop. It returns to 1 the cycle after that pop.
- Reset mid-operation:
  - All state clears asynchronously.
  - The system must reset `fadd` in the same window.
  - Any `fadd_res_val` arriving after reset from pre-reset issues is handled as an orphan.

## Structure
- `fadd_pkg` holds:
  - `FADD_LAT`=3.
  - Default `N`/`E`/`S`.
  - typedef `fadd_res_t` = packed `{res, tag}`.
- Sub-module `fadd_sfifo`: parameterised width/depth synchronous FIFO with `count`, `full` and `empty` outputs, async active-low reset, and registered head. It is instantiated twice: tag FIFO and result FIFO.

## Test plan
- Single op: 1.0+2.0 (`0x3F800000`, `0x40000000`), tag 5, `out_ready`=1 → `fadd_en` in cycle 0; `out_valid` in cycle 4 with `out_res`=`0x40400000`, `out_tag`=5; `busy` returns to 0 afterwards.
- Streaming: 20 back-to-back ops, tags 0..15 wrapping, `out_ready`=1 → `in_ready` never drops; results appear in order, one per cycle, starting at cycle 4.
- Back-pressure: `out_ready`=0, `in_valid`=1 → exactly 8 fires, then `in_ready`=0. Raise `out_ready` → `in_ready`=1 the cycle after the first pop; tag order is preserved.
- Simultaneous events: issue in the same cycle as a result return and an out-pop → all counts stay consistent, no error flags.
- Orphan: inject `fadd_res_val` with nothing in flight → `err_orphan`=1 and stays sticky, `out_valid` stays 0.
- Async reset: assert `rst_n`=0 mid-stream, off a clock edge → all outputs reach their reset values immediately. A post-reset stray `fadd_res_val` sets `err_orphan`.
